// File: rtl/lv_efuse_ctrl_pkg.sv
// Shared types and default parameters for the LV-die eFuse loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lv_efuse_ctrl_pkg;

  localparam int              EFUSE_WORD_NUM_DFLT = 8;
  localparam int              EFUSE_DATA_W_DFLT   = 8;
  localparam int              EFUSE_ADDR_W_DFLT   = 3;
  localparam int              REG_ADDR_W_DFLT     = 7;
  localparam logic [6:0]      EFUSE_REG_BASE_DFLT = 7'h40;
  localparam int              SETUP_CYC_DFLT      = 2;
  localparam int              RD_PULSE_CYC_DFLT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CAPT    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_RELEASE = 3'd6
  } efuse_st_e;

endpackage

// File: rtl/lv_efuse_ctrl_if.sv
// Bundle of load handshake, eFuse macro and register-bank write signals.
// Latency: n/a (wiring only).
// Backpressure: none; request is a level held until done is seen.
// slave  : the loader (consumes request + read data, drives everything else)
// master : the environment (control FSM, fuse macro, register bank)
interface lv_efuse_ctrl_if
  import lv_efuse_ctrl_pkg::*;
#(
  parameter int EFUSE_ADDR_W = EFUSE_ADDR_W_DFLT,
  parameter int EFUSE_DATA_W = EFUSE_DATA_W_DFLT,
  parameter int REG_ADDR_W   = REG_ADDR_W_DFLT
);
  logic                    i_efuse_load_req;
  logic                    o_efuse_load_done;
  logic                    o_efuse_vld;
  logic                    o_efuse_busy;
  logic                    o_efuse_csb;
  logic                    o_efuse_strobe;
  logic [EFUSE_ADDR_W-1:0] o_efuse_addr;
  logic [EFUSE_DATA_W-1:0] i_efuse_rdata;
  logic                    o_efuse_reg_wr_en;
  logic [REG_ADDR_W-1:0]   o_efuse_reg_wr_addr;
  logic [EFUSE_DATA_W-1:0] o_efuse_reg_wr_data;

  modport slave (
    input  i_efuse_load_req, i_efuse_rdata,
    output o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_csb,
           o_efuse_strobe, o_efuse_addr, o_efuse_reg_wr_en,
           o_efuse_reg_wr_addr, o_efuse_reg_wr_data
  );

  modport master (
    output i_efuse_load_req, i_efuse_rdata,
    input  o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_csb,
           o_efuse_strobe, o_efuse_addr, o_efuse_reg_wr_en,
           o_efuse_reg_wr_addr, o_efuse_reg_wr_data
  );
endinterface

// File: rtl/lv_efuse_rd_timer.sv
// Phase timer: down-counter loaded per phase, flags expiry when it reaches zero.
// Latency: expired asserts load_val cycles after the load cycle.
// Backpressure: none; a load always overrides the running count.
// Ports: clk, rst_n (sync, active-low), load, load_val -> expired
module lv_efuse_rd_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/lv_efuse_ctrl.sv
// eFuse loader: reads every fuse word, mirrors it into the register bank, checks the checksum.
// Latency: done pulse N*(SETUP_CYC+RD_PULSE_CYC+1)+2 cycles after the request is first high.
// Backpressure: none; request is a held level, loads run to completion and re-arm only after request drops.
// Ports: i_clk, i_rst_n (sync, active-low), efuse (slave modport: request/done/vld/busy,
//        macro csb/strobe/addr/rdata, register write en/addr/data).
module lv_efuse_ctrl
  import lv_efuse_ctrl_pkg::*;
#(
  parameter int                    EFUSE_WORD_NUM = EFUSE_WORD_NUM_DFLT,
  parameter int                    EFUSE_DATA_W   = EFUSE_DATA_W_DFLT,
  parameter int                    EFUSE_ADDR_W   = EFUSE_ADDR_W_DFLT,
  parameter int                    REG_ADDR_W     = REG_ADDR_W_DFLT,
  parameter logic [REG_ADDR_W-1:0] EFUSE_REG_BASE = EFUSE_REG_BASE_DFLT,
  parameter int                    SETUP_CYC      = SETUP_CYC_DFLT,
  parameter int                    RD_PULSE_CYC   = RD_PULSE_CYC_DFLT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lv_efuse_ctrl_if.slave efuse
);

  if (EFUSE_WORD_NUM < 2) begin : g_chk_word_num
    $error("EFUSE_WORD_NUM must be >= 2");
  end
  if ((1 << EFUSE_ADDR_W) < EFUSE_WORD_NUM) begin : g_chk_addr_w
    $error("EFUSE_ADDR_W too narrow for EFUSE_WORD_NUM");
  end
  if (SETUP_CYC < 1) begin : g_chk_setup
    $error("SETUP_CYC must be >= 1");
  end
  if (RD_PULSE_CYC < 1) begin : g_chk_pulse
    $error("RD_PULSE_CYC must be >= 1");
  end

  localparam int TMR_MAX = (SETUP_CYC > RD_PULSE_CYC) ? SETUP_CYC : RD_PULSE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  efuse_st_e               state;
  logic [EFUSE_ADDR_W-1:0] idx;
  logic [EFUSE_DATA_W-1:0] acc;      // XOR of all words read, checksum included
  logic                    any_nz;   // sticky: some word was non-zero
  logic                    load_done, efuse_vld, busy, csb, strobe, wr_en;
  logic [EFUSE_ADDR_W-1:0] addr;
  logic [REG_ADDR_W-1:0]   wr_addr;
  logic [EFUSE_DATA_W-1:0] wr_data;

  logic             tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic             valid;

  // Timer is armed on every entry into SETUP and on the SETUP->STROBE hand-over.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(SETUP_CYC - 1);
    if ((state == ST_IDLE && efuse.i_efuse_load_req) ||
        (state == ST_CAPT && idx != LAST_IDX)) begin
      tmr_load = 1'b1;
    end else if (state == ST_SETUP && tmr_exp) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(RD_PULSE_CYC - 1);
    end
  end

  lv_efuse_rd_timer #(.CNT_W(TMR_W)) u_rd_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Including the checksum word in the XOR turns the compare into a zero test.
  assign valid = (acc == '0) && any_nz;

  // Outputs are assigned for the state being entered, so every output is a flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      any_nz    <= 1'b0;
      load_done <= 1'b0;
      efuse_vld <= 1'b0;
      busy      <= 1'b0;
      csb       <= 1'b1;
      strobe    <= 1'b0;
      addr      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      load_done <= 1'b0;
      wr_en     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (efuse.i_efuse_load_req) begin
            idx    <= '0;
            acc    <= '0;
            any_nz <= 1'b0;
            busy   <= 1'b1;
            csb    <= 1'b0;
            strobe <= 1'b0;
            addr   <= '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_exp) begin
            strobe <= 1'b1;
            state  <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_exp) begin
            strobe  <= 1'b0;
            wr_en   <= 1'b1;
            wr_data <= efuse.i_efuse_rdata;
            wr_addr <= EFUSE_REG_BASE + REG_ADDR_W'(idx);
            acc     <= acc ^ efuse.i_efuse_rdata;
            any_nz  <= any_nz | (|efuse.i_efuse_rdata);
            state   <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (idx == LAST_IDX) begin
            csb   <= 1'b1;
            state <= ST_CHECK;
          end else begin
            idx   <= idx + 1'b1;
            addr  <= idx + 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_CHECK: begin
          load_done <= 1'b1;
          efuse_vld <= valid;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Requester still holds the level for a cycle after done; wait for it to fall.
          if (!efuse.i_efuse_load_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign efuse.o_efuse_load_done   = load_done;
  assign efuse.o_efuse_vld         = efuse_vld;
  assign efuse.o_efuse_busy        = busy;
  assign efuse.o_efuse_csb         = csb;
  assign efuse.o_efuse_strobe      = strobe;
  assign efuse.o_efuse_addr        = addr;
  assign efuse.o_efuse_reg_wr_en   = wr_en;
  assign efuse.o_efuse_reg_wr_addr = wr_addr;
  assign efuse.o_efuse_reg_wr_data = wr_data;

endmodule

// File: tb/tb_lv_efuse_ctrl.sv
// Self-checking bench for lv_efuse_ctrl: directed cases plus random fuse images.
// Latency: expects done 58 cycles after request with default parameters.
// Backpressure: request held as a level; dropped one cycle after done unless a case says otherwise.
module tb_lv_efuse_ctrl;
  localparam int N    = 8;
  localparam int SU   = 2;
  localparam int RD   = 4;
  localparam int W    = SU + RD + 1;
  localparam int LAT  = N * W + 2;
  localparam int BASE = 'h40;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  logic model_vld;
  logic [7:0] fuse [N];

  lv_efuse_ctrl_if #(.EFUSE_ADDR_W(3), .EFUSE_DATA_W(8), .REG_ADDR_W(7)) efuse ();

  lv_efuse_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .efuse   (efuse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One complete load. drop_c: cycle the request falls early (-1 = never);
  // hold: extra cycles the request stays high after the normal drop point.
  task automatic run_load(input int drop_c, input int hold);
    int   wr_cnt, done_cnt, done_c, stb_cnt, run, busy_err, vld_err, csb_err;
    logic [7:0] x;
    logic nz, exp_vld, exp_busy, exp_csb, exp_cur_vld;
    wr_cnt = 0; done_cnt = 0; done_c = -1; stb_cnt = 0; run = 0;
    busy_err = 0; vld_err = 0; csb_err = 0;
    x = '0; nz = 1'b0;
    for (int k = 0; k < N - 1; k++) x ^= fuse[k];
    for (int k = 0; k < N; k++) nz |= (fuse[k] != 8'h00);
    exp_vld = (x == fuse[N-1]) && nz;

    for (int c = 0; c < LAT + hold + 4; c++) begin
      @(negedge clk);
      if (c == 0) efuse.i_efuse_load_req = 1'b1;
      if (c == drop_c) efuse.i_efuse_load_req = 1'b0;
      if (c == LAT + 1 + hold) efuse.i_efuse_load_req = 1'b0;

      // Fuse macro: data is only valid in the last cycle of a full-length strobe.
      if (efuse.o_efuse_strobe) begin
        run++;
        stb_cnt++;
      end else begin
        run = 0;
      end
      efuse.i_efuse_rdata = (efuse.o_efuse_strobe && run == RD) ?
                            fuse[efuse.o_efuse_addr] : 8'($urandom);

      if (efuse.o_efuse_reg_wr_en) begin
        if (wr_cnt < N) begin
          chk("wr_cycle", c, (wr_cnt + 1) * W);
          chk("wr_addr", efuse.o_efuse_reg_wr_addr, BASE + wr_cnt);
          chk("wr_data", efuse.o_efuse_reg_wr_data, fuse[wr_cnt]);
        end
        wr_cnt++;
      end
      if (efuse.o_efuse_load_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_c = c;
          chk("done_vld", efuse.o_efuse_vld, exp_vld);
        end
      end
      exp_busy    = (c >= 1 && c <= LAT);
      exp_csb     = !(c >= 1 && c <= N * W);
      exp_cur_vld = (c >= LAT) ? exp_vld : model_vld;
      if (efuse.o_efuse_busy !== exp_busy) busy_err++;
      if (efuse.o_efuse_csb !== exp_csb) csb_err++;
      if (efuse.o_efuse_vld !== exp_cur_vld) vld_err++;
    end
    model_vld = exp_vld;
    chk("wr_count", wr_cnt, N);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_c, LAT);
    chk("strobe_cycles", stb_cnt, N * RD);
    chk("busy_window_errs", busy_err, 0);
    chk("csb_window_errs", csb_err, 0);
    chk("vld_hold_errs", vld_err, 0);
  endtask

  task automatic set_good(input logic [7:0] seed);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < N - 1; k++) begin
      fuse[k] = seed * 8'(k + 1);
      x ^= fuse[k];
    end
    fuse[N-1] = x;
  endtask

  task automatic run_reset_mid();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 0) efuse.i_efuse_load_req = 1'b1;
      efuse.i_efuse_rdata = fuse[efuse.o_efuse_addr];
      if (c == 20) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("rst_csb", efuse.o_efuse_csb, 1'b1);
    chk("rst_strobe", efuse.o_efuse_strobe, 1'b0);
    chk("rst_wr_en", efuse.o_efuse_reg_wr_en, 1'b0);
    chk("rst_vld", efuse.o_efuse_vld, 1'b0);
    chk("rst_done", efuse.o_efuse_load_done, 1'b0);
    chk("rst_busy", efuse.o_efuse_busy, 1'b0);
    efuse.i_efuse_load_req = 1'b0;
    model_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] x;
    int drop;
    n_checks = 0;
    n_err    = 0;
    model_vld = 1'b0;
    rst_n = 1'b0;
    efuse.i_efuse_load_req = 1'b0;
    efuse.i_efuse_rdata    = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", efuse.o_efuse_load_done, 1'b0);
    chk("reset_vld", efuse.o_efuse_vld, 1'b0);
    chk("reset_busy", efuse.o_efuse_busy, 1'b0);
    chk("reset_csb", efuse.o_efuse_csb, 1'b1);
    chk("reset_strobe", efuse.o_efuse_strobe, 1'b0);
    chk("reset_addr", efuse.o_efuse_addr, 0);
    chk("reset_wr_en", efuse.o_efuse_reg_wr_en, 1'b0);
    chk("reset_wr_addr", efuse.o_efuse_reg_wr_addr, 0);
    chk("reset_wr_data", efuse.o_efuse_reg_wr_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal load: 0x11..0x77 XOR to 0x00, stored as the checksum.
    for (int k = 0; k < N - 1; k++) fuse[k] = 8'(8'h11 * (k + 1));
    fuse[N-1] = 8'h00;
    run_load(-1, 0);
    // Bad checksum.
    fuse[N-1] = 8'h01;
    run_load(-1, 0);
    // Blank fuse: XOR matches but must be rejected.
    for (int k = 0; k < N; k++) fuse[k] = 8'h00;
    run_load(-1, 0);
    // Request held 10 cycles past done, then a fresh request.
    set_good(8'h5a);
    run_load(-1, 10);
    run_load(-1, 0);
    // Request dropped early.
    set_good(8'h13);
    run_load(10, 0);
    // Reset mid-load, then restart from word 0.
    run_reset_mid();
    set_good(8'h27);
    run_load(-1, 0);

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N; k++) fuse[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        x = '0;
        for (int k = 0; k < N - 1; k++) x ^= fuse[k];
        fuse[N-1] = x;
      end
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : -1;
      run_load(drop, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
